// File: rtl/mram_access_arbiter.sv
// Two-port round-robin arbiter that runs one MRAM controller frame per grant,
// feeding address/write data serially and assembling serial read data into a word.
module mram_access_arbiter #(
  parameter int WR_FRAME     = 22,
  parameter int RD_FRAME     = 40,
  parameter int RD_CAP_START = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic [2:0]  op0,
  input  logic [19:0] addr0,
  input  logic [15:0] wdata0,
  input  logic        req1,
  input  logic [2:0]  op1,
  input  logic [19:0] addr1,
  input  logic [15:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [15:0] rdata,
  output logic        ctrl_rst,
  output logic [2:0]  ctrl_sel,
  output logic        ser_addr_bit,
  output logic        ser_data_bit,
  input  logic        mram_rx_bit
);

  localparam int MAX_FRAME = (RD_FRAME > WR_FRAME) ? RD_FRAME : WR_FRAME;
  localparam int FW        = $clog2(MAX_FRAME);
  localparam logic [FW-1:0] WR_LAST   = FW'(WR_FRAME - 1);
  localparam logic [FW-1:0] RD_LAST   = FW'(RD_FRAME - 1);
  localparam logic [FW-1:0] CAP_FIRST = FW'(RD_CAP_START);
  localparam logic [FW-1:0] ONE       = FW'(1);
  localparam logic [FW-1:0] ADDR_END  = FW'(20);
  localparam logic [FW-1:0] DATA_END  = FW'(16);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FRAME = 2'd1, S_DONE = 2'd2} state_t;

  state_t        r_state, w_state_nxt;
  logic [FW-1:0] r_f, w_f_nxt;
  logic          r_hold, w_hold_nxt;
  logic          r_ptr, r_port;
  logic [2:0]    r_op;
  logic [19:0]   r_addr_sh;
  logic [15:0]   r_wdata_sh, r_cap, r_rdata;
  logic          r_gnt0, r_gnt1, r_done0, r_done1;
  logic          r_ctrl_rst, r_ser_addr, r_ser_data;
  logic [2:0]    r_ctrl_sel;

  logic          w_any, w_win, w_port_nxt, w_in_frame, w_done_nxt;
  logic [2:0]    w_win_op, w_op_nxt, w_ctrl_sel;
  logic [19:0]   w_win_addr;
  logic [15:0]   w_win_wdata, w_cap_full, w_rdata_nxt;
  logic [FW-1:0] w_last_f;
  logic          w_addr_shift, w_data_shift, w_capture, w_rd_done;

  // Round robin: on contention the pointer decides, a lone requester always wins.
  assign w_any       = req0 | req1;
  assign w_win       = (req0 & req1) ? r_ptr : req1;
  assign w_win_op    = w_win ? op1    : op0;
  assign w_win_addr  = w_win ? addr1  : addr0;
  assign w_win_wdata = w_win ? wdata1 : wdata0;
  assign w_last_f    = r_op[0] ? WR_LAST : RD_LAST;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_f     <= '0;
      r_hold  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state <= w_state_nxt;
      r_f     <= w_f_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned (no latches).
    w_state_nxt = r_state;
    w_f_nxt     = r_f;
    w_hold_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          if (w_win_op[2:1] == 2'b00) begin
            w_state_nxt = S_DONE;
            w_hold_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_FRAME;
            w_f_nxt     = '0;
          end
        end
      end
      S_FRAME: begin
        if (r_f == w_last_f) w_state_nxt = S_DONE;
        else                 w_f_nxt     = r_f + ONE;
      end
      S_DONE:  w_state_nxt = r_hold ? S_DONE : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are computed from the next state so that they can be registered.
  always_comb begin
    w_port_nxt   = (r_state == S_IDLE) ? w_win    : r_port;
    w_op_nxt     = (r_state == S_IDLE) ? w_win_op : r_op;
    w_in_frame   = (w_state_nxt == S_FRAME);
    w_done_nxt   = (w_state_nxt == S_DONE) && !w_hold_nxt;
    w_ctrl_sel   = w_in_frame ? w_op_nxt : 3'b000;
    w_addr_shift = w_in_frame && (w_f_nxt >= ONE) && (w_f_nxt <= ADDR_END);
    w_data_shift = w_in_frame && r_op[0] && (w_f_nxt >= ONE) && (w_f_nxt <= DATA_END);
    w_capture    = (r_state == S_FRAME) && !r_op[0] && (r_f >= CAP_FIRST);
    w_rd_done    = (r_state == S_FRAME) && (w_state_nxt == S_DONE) && !r_op[0];
    w_cap_full   = {r_cap[14:0], mram_rx_bit};
    case (r_op[2:1])
      2'b11:   w_rdata_nxt = w_cap_full;
      2'b01:   w_rdata_nxt = {8'h00, w_cap_full[15:8]};
      2'b10:   w_rdata_nxt = {w_cap_full[15:8], 8'h00};
      default: w_rdata_nxt = r_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr      <= 1'b0;
      r_port     <= 1'b0;
      r_op       <= 3'b000;
      r_addr_sh  <= '0;
      r_wdata_sh <= '0;
      r_cap      <= '0;
      r_rdata    <= '0;
      r_gnt0     <= 1'b0;
      r_gnt1     <= 1'b0;
      r_done0    <= 1'b0;
      r_done1    <= 1'b0;
      r_ctrl_rst <= 1'b1;
      r_ctrl_sel <= 3'b000;
      r_ser_addr <= 1'b0;
      r_ser_data <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_any) begin
        r_port     <= w_win;
        r_op       <= w_win_op;
        r_addr_sh  <= w_win_addr;
        r_wdata_sh <= w_win_wdata;
      end else begin
        if (w_addr_shift) r_addr_sh  <= {r_addr_sh[18:0], 1'b0};
        if (w_data_shift) r_wdata_sh <= {r_wdata_sh[14:0], 1'b0};
      end
      if (r_state == S_DONE && !r_hold) r_ptr <= ~r_port;
      if (w_capture) r_cap   <= w_cap_full;
      if (w_rd_done) r_rdata <= w_rdata_nxt;
      r_gnt0     <= (w_state_nxt != S_IDLE) && !w_port_nxt;
      r_gnt1     <= (w_state_nxt != S_IDLE) &&  w_port_nxt;
      r_done0    <= w_done_nxt && !w_port_nxt;
      r_done1    <= w_done_nxt &&  w_port_nxt;
      r_ctrl_rst <= !w_in_frame;
      r_ctrl_sel <= w_ctrl_sel;
      r_ser_addr <= w_addr_shift && r_addr_sh[19];
      r_ser_data <= w_data_shift && r_wdata_sh[15];
    end
  end

  assign gnt0         = r_gnt0;
  assign gnt1         = r_gnt1;
  assign done0        = r_done0;
  assign done1        = r_done1;
  assign rdata        = r_rdata;
  assign ctrl_rst     = r_ctrl_rst;
  assign ctrl_sel     = r_ctrl_sel;
  assign ser_addr_bit = r_ser_addr;
  assign ser_data_bit = r_ser_data;

endmodule
